// File: rtl/gb_envelope_multi.sv
// Multi-channel volume envelope generator.
// NUM_CH independent units share one frame-sequencer envelope tick. Each unit
// latches its settings on start, counts ticks down from the sweep period and
// steps its volume by one toward the selected bound until it saturates.
module gb_envelope_multi #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned VOL_W    = 4,
  parameter int unsigned PERIOD_W = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clk_vol_env,
  input  logic [NUM_CH-1:0]            start,
  input  logic [NUM_CH*VOL_W-1:0]      initial_volume,
  input  logic [NUM_CH-1:0]            envelope_increasing,
  input  logic [NUM_CH*PERIOD_W-1:0]   num_envelope_sweeps,
  output logic [NUM_CH*VOL_W-1:0]      target_vol,
  output logic [NUM_CH-1:0]            envelope_active,
  output logic [NUM_CH-1:0]            dac_enable
);

  localparam logic [VOL_W-1:0]    VolMax   = '1;
  localparam logic [VOL_W-1:0]    VolOne   = VOL_W'(1);
  localparam logic [PERIOD_W-1:0] PeriodOne = PERIOD_W'(1);

  for (genvar i = 0; i < int'(NUM_CH); i++) begin : g_ch
    logic [VOL_W-1:0]    vol_q, vol_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] per_q, per_d;
    logic                inc_q, inc_d;
    logic                act_q, act_d;
    logic                dac_q, dac_d;

    logic [VOL_W-1:0]    iv;
    logic [PERIOD_W-1:0] per_in;
    logic                inc_in;

    assign iv     = initial_volume[i*VOL_W +: VOL_W];
    assign per_in = num_envelope_sweeps[i*PERIOD_W +: PERIOD_W];
    assign inc_in = envelope_increasing[i];

    // Next state: start reloads everything (and swallows a coincident tick),
    // otherwise an active unit counts ticks and steps on each period expiry.
    always_comb begin
      vol_d = vol_q;
      cnt_d = cnt_q;
      per_d = per_q;
      inc_d = inc_q;
      act_d = act_q;
      dac_d = dac_q;
      if (start[i]) begin
        vol_d = iv;
        cnt_d = per_in;
        per_d = per_in;
        inc_d = inc_in;
        dac_d = (iv != '0) | inc_in;
        act_d = (per_in != '0) & (inc_in ? (iv != VolMax) : (iv != '0));
      end else if (clk_vol_env && act_q) begin
        if (cnt_q > PeriodOne) begin
          cnt_d = cnt_q - PeriodOne;
        end else begin
          cnt_d = per_q;
          if (inc_q) begin
            vol_d = vol_q + VolOne;
            // Stop in the same update that reaches the bound.
            if (vol_q == VolMax - VolOne) act_d = 1'b0;
          end else begin
            vol_d = vol_q - VolOne;
            if (vol_q == VolOne) act_d = 1'b0;
          end
        end
      end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
      if (reset) begin
        vol_q <= '0;
        cnt_q <= '0;
        per_q <= '0;
        inc_q <= 1'b0;
        act_q <= 1'b0;
        dac_q <= 1'b0;
      end else begin
        vol_q <= vol_d;
        cnt_q <= cnt_d;
        per_q <= per_d;
        inc_q <= inc_d;
        act_q <= act_d;
        dac_q <= dac_d;
      end
    end

    assign target_vol[i*VOL_W +: VOL_W] = vol_q;
    assign envelope_active[i]           = act_q;
    assign dac_enable[i]                = dac_q;
  end

endmodule

// File: tb/tb_gb_envelope_multi.sv
// Directed bench for gb_envelope_multi: a vector table of trigger/tick runs
// plus hand-written sequences for idle reset, held tick, re-trigger/collision
// and mid-sweep reset.
module tb_gb_envelope_multi;

  localparam int NCH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          clk_vol_env;
  logic [3:0]    start;
  logic [15:0]   initial_volume;
  logic [3:0]    envelope_increasing;
  logic [11:0]   num_envelope_sweeps;
  logic [15:0]   target_vol;
  logic [3:0]    envelope_active;
  logic [3:0]    dac_enable;

  int total = 0;
  int bad   = 0;

  gb_envelope_multi #(.NUM_CH(4), .VOL_W(4), .PERIOD_W(3)) dut (
    .clk                 (clk),
    .reset               (reset),
    .clk_vol_env         (clk_vol_env),
    .start               (start),
    .initial_volume      (initial_volume),
    .envelope_increasing (envelope_increasing),
    .num_envelope_sweeps (num_envelope_sweeps),
    .target_vol          (target_vol),
    .envelope_active     (envelope_active),
    .dac_enable          (dac_enable)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       ch;
    bit [3:0] iv;
    bit       inc;
    bit [2:0] per;
    int       ticks;
    bit [3:0] exp_vol;
    bit       exp_act;
    bit       exp_dac;
  } vec_t;

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  function automatic int vol_of(input int ch);
    return int'(target_vol[ch*4 +: 4]);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    clk_vol_env = 1'b1;
    step();
    clk_vol_env = 1'b0;
  endtask

  task automatic set_ch(input int ch, input bit [3:0] iv, input bit inc, input bit [2:0] per);
    initial_volume[ch*4 +: 4]      = iv;
    envelope_increasing[ch]        = inc;
    num_envelope_sweeps[ch*3 +: 3] = per;
  endtask

  task automatic trig(input int ch, input bit [3:0] iv, input bit inc, input bit [2:0] per);
    set_ch(ch, iv, inc, per);
    start[ch] = 1'b1;
    step();
    start[ch] = 1'b0;
  endtask

  vec_t vecs[$];

  initial begin
    reset = 1'b1;
    clk_vol_env = 1'b0;
    start = '0;
    initial_volume = '0;
    envelope_increasing = '0;
    num_envelope_sweeps = '0;

    // ch, iv, inc, per, ticks, exp_vol, exp_act, exp_dac
    vecs.push_back('{0,  0, 1, 1,  5,  5, 1, 1});
    vecs.push_back('{0,  0, 1, 1, 15, 15, 0, 1});
    vecs.push_back('{0,  0, 1, 1, 20, 15, 0, 1});
    vecs.push_back('{1, 15, 0, 3,  2, 15, 1, 1});
    vecs.push_back('{1, 15, 0, 3,  3, 14, 1, 1});
    vecs.push_back('{1, 15, 0, 3, 44,  1, 1, 1});
    vecs.push_back('{1, 15, 0, 3, 45,  0, 0, 1});
    vecs.push_back('{1, 15, 0, 3, 48,  0, 0, 1});
    vecs.push_back('{2,  0, 0, 2,  6,  0, 0, 0});
    vecs.push_back('{3,  7, 1, 0, 10,  7, 0, 1});
    vecs.push_back('{3,  7, 0, 0, 10,  7, 0, 1});
    vecs.push_back('{2, 15, 1, 5,  3, 15, 0, 1});
    vecs.push_back('{2,  3, 0, 7, 14,  1, 1, 1});

    // Reset then idle with ticks
    step();
    step();
    reset = 1'b0;
    for (int t = 0; t < 10; t++) do_tick();
    check("idle_vol", int'(target_vol), 0);
    check("idle_act", int'(envelope_active), 0);
    check("idle_dac", int'(dac_enable), 0);

    // Table-driven runs
    foreach (vecs[k]) begin
      trig(vecs[k].ch, vecs[k].iv, vecs[k].inc, vecs[k].per);
      check($sformatf("v%0d_load_vol", k), vol_of(vecs[k].ch), int'(vecs[k].iv));
      for (int t = 0; t < vecs[k].ticks; t++) do_tick();
      check($sformatf("v%0d_vol", k), vol_of(vecs[k].ch), int'(vecs[k].exp_vol));
      check($sformatf("v%0d_act", k), int'(envelope_active[vecs[k].ch]), int'(vecs[k].exp_act));
      check($sformatf("v%0d_dac", k), int'(dac_enable[vecs[k].ch]), int'(vecs[k].exp_dac));
    end

    // Ch0 per-tick trace, period 1 upward
    trig(0, 4'd0, 1'b1, 3'd1);
    for (int t = 1; t <= 17; t++) begin
      do_tick();
      check($sformatf("trace_t%0d", t), vol_of(0), (t > 15) ? 15 : t);
    end

    // Tick held high for 3 cycles counts as 3 ticks
    trig(0, 4'd0, 1'b1, 3'd1);
    clk_vol_env = 1'b1;
    step(); step(); step();
    clk_vol_env = 1'b0;
    step();
    check("held_tick", vol_of(0), 3);

    // Re-trigger and start/tick collision
    trig(1, 4'd0, 1'b1, 3'd1);
    trig(0, 4'd4, 1'b1, 3'd2);
    for (int t = 0; t < 3; t++) do_tick();
    check("col_vol_after3", vol_of(0), 5);
    set_ch(0, 4'd9, 1'b1, 3'd2);
    step();
    check("col_no_start", vol_of(0), 5);
    do_tick();
    check("col_tick4", vol_of(0), 6);
    check("col_ch1_before", vol_of(1), 4);
    start[0] = 1'b1;
    do_tick();
    start[0] = 1'b0;
    check("col_start_wins", vol_of(0), 9);
    check("col_ch1_shared", vol_of(1), 5);
    do_tick();
    check("col_next1", vol_of(0), 9);
    do_tick();
    check("col_next2", vol_of(0), 10);
    check("col_ch1_after", vol_of(1), 7);

    // Reset mid-sweep
    trig(1, 4'd15, 1'b0, 3'd1);
    for (int t = 0; t < 7; t++) do_tick();
    check("rst_pre_vol", vol_of(1), 8);
    check("rst_pre_act", int'(envelope_active[1]), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_vol", vol_of(1), 0);
    check("rst_act", int'(envelope_active[1]), 0);
    check("rst_dac", int'(dac_enable[1]), 0);
    for (int t = 0; t < 3; t++) do_tick();
    check("rst_idle_vol", vol_of(1), 0);
    check("rst_idle_act", int'(envelope_active[1]), 0);
    trig(1, 4'd6, 1'b0, 3'd1);
    do_tick();
    check("rst_retrig", vol_of(1), 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
